unit_addr_decoder_n: RTL and testbench

- Parametrised successor of the 5-slave unit address decoder.
- Accepts one bus transaction (read or write) from an upstream master through a valid/ready handshake.
- Decodes the address to one of N_SLAVES address windows and drives a one-hot slave select, address, write data and direction.
- Waits for the selected slave's ack, returns read data and a done/error pulse. A missing ack ends in a timeout error; an address outside every window ends in a decode error.

---
 rtl/unit_addr_decoder_n.sv | 126 ++++++++++++
 tb/tb_unit_addr_decoder_n.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/unit_addr_decoder_n.sv
`default_nettype none
// ============================================================================
// Module   : unit_addr_decoder_n
// Brief    : Valid/ready request decoder onto N windowed slaves, with ack wait,
//            timeout and decode-error completion.
// Revision : 1.0  initial release
// ============================================================================
module unit_addr_decoder_n #(
    parameter int N_SLAVES = 5,
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int WIN_BITS = 5,
    parameter int TIMEOUT  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                valid_in,
    output logic                ready_out,
    input  logic                wr_rd_s_in,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   wr_data_in,
    output logic                done_out,
    output logic                err_out,
    output logic [DATA_W-1:0]   rd_data_out,
    output logic [N_SLAVES-1:0] sel_en_out,
    output logic                wr_rd_s_out,
    output logic [ADDR_W-1:0]   addr_out,
    output logic [DATA_W-1:0]   wr_data_out,
    input  logic [DATA_W-1:0]   rd_data_in,
    input  logic [N_SLAVES-1:0] ack_in
);

    localparam int CNT_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;

    logic [ADDR_W-1:0]   w_idx;
    logic [N_SLAVES-1:0] w_sel;
    logic                w_hit;
    logic                w_ack;
    logic                w_timeout;

    assign w_idx = addr_in >> WIN_BITS;

    // An index beyond the last slave matches no bit, which is the decode error.
    generate
        for (genvar i = 0; i < N_SLAVES; i++) begin : g_sel
            assign w_sel[i] = (w_idx == ADDR_W'(i));
        end
    endgenerate

    assign w_hit     = |w_sel;
    assign w_ack     = |(sel_en_out & ack_in);
    assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            ready_out   <= 1'b1;
            done_out    <= 1'b0;
            err_out     <= 1'b0;
            rd_data_out <= '0;
            sel_en_out  <= '0;
            wr_rd_s_out <= 1'b0;
            addr_out    <= '0;
            wr_data_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done_out <= 1'b0;
                    err_out  <= 1'b0;
                    if (valid_in) begin
                        ready_out <= 1'b0;
                        if (w_hit) begin
                            r_state     <= S_ACCESS;
                            r_cnt       <= '0;
                            sel_en_out  <= w_sel;
                            addr_out    <= addr_in;
                            wr_data_out <= wr_data_in;
                            wr_rd_s_out <= wr_rd_s_in;
                        end else begin
                            r_state     <= S_RESP;
                            done_out    <= 1'b1;
                            err_out     <= 1'b1;
                            rd_data_out <= '0;
                        end
                    end
                end
                S_ACCESS: begin
                    // An ack on the final counted cycle still completes cleanly.
                    if (w_ack || w_timeout) begin
                        r_state     <= S_RESP;
                        done_out    <= 1'b1;
                        err_out     <= !w_ack;
                        rd_data_out <= (w_ack && !wr_rd_s_out) ? rd_data_in : '0;
                        sel_en_out  <= '0;
                        addr_out    <= '0;
                        wr_data_out <= '0;
                        wr_rd_s_out <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_state   <= S_IDLE;
                    done_out  <= 1'b0;
                    err_out   <= 1'b0;
                    ready_out <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_unit_addr_decoder_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_unit_addr_decoder_n
// Brief    : Directed bench with a transaction-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_unit_addr_decoder_n;

    localparam int N_SLAVES = 5;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 8;
    localparam int WIN_BITS = 5;
    localparam int TIMEOUT  = 16;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic                valid_in = 1'b0;
    logic                ready_out;
    logic                wr_rd_s_in = 1'b0;
    logic [ADDR_W-1:0]   addr_in = '0;
    logic [DATA_W-1:0]   wr_data_in = '0;
    logic                done_out;
    logic                err_out;
    logic [DATA_W-1:0]   rd_data_out;
    logic [N_SLAVES-1:0] sel_en_out;
    logic                wr_rd_s_out;
    logic [ADDR_W-1:0]   addr_out;
    logic [DATA_W-1:0]   wr_data_out;
    logic [DATA_W-1:0]   rd_data_in = '0;
    logic [N_SLAVES-1:0] ack_in = '0;

    int total = 0;
    int bad   = 0;
    bit run_chk = 1'b0;

    unit_addr_decoder_n #(
        .N_SLAVES(N_SLAVES), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .WIN_BITS(WIN_BITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .wr_rd_s_in(wr_rd_s_in), .addr_in(addr_in), .wr_data_in(wr_data_in),
        .done_out(done_out), .err_out(err_out), .rd_data_out(rd_data_out),
        .sel_en_out(sel_en_out), .wr_rd_s_out(wr_rd_s_out), .addr_out(addr_out),
        .wr_data_out(wr_data_out), .rd_data_in(rd_data_in), .ack_in(ack_in)
    );

    always #5 clock = ~clock;

    // Reference model: phase 0 = waiting, 1 = talking to slave, 2 = reporting.
    int                  m_phase = 0;
    int                  m_idx   = 0;
    int                  m_wait  = 0;
    logic                exp_ready = 1'b1;
    logic                exp_done  = 1'b0;
    logic                exp_err   = 1'b0;
    logic [DATA_W-1:0]   exp_rd    = '0;
    logic [N_SLAVES-1:0] exp_sel   = '0;
    logic                exp_wr    = 1'b0;
    logic [ADDR_W-1:0]   exp_addr  = '0;
    logic [DATA_W-1:0]   exp_wd    = '0;

    task automatic bus_idle();
        exp_sel = '0; exp_addr = '0; exp_wd = '0; exp_wr = 1'b0;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_phase = 0; exp_ready = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
            exp_rd = '0; bus_idle();
        end else begin
            case (m_phase)
                0: begin
                    exp_done = 1'b0; exp_err = 1'b0;
                    if (valid_in) begin
                        exp_ready = 1'b0;
                        m_idx = int'(addr_in) / (1 << WIN_BITS);
                        if (m_idx < N_SLAVES) begin
                            m_phase = 1; m_wait = 0;
                            exp_sel = N_SLAVES'(1 << m_idx);
                            exp_addr = addr_in; exp_wd = wr_data_in; exp_wr = wr_rd_s_in;
                        end else begin
                            m_phase = 2; exp_done = 1'b1; exp_err = 1'b1; exp_rd = '0;
                        end
                    end
                end
                1: begin
                    if (ack_in[m_idx]) begin
                        exp_rd = exp_wr ? '0 : rd_data_in;
                        exp_done = 1'b1; exp_err = 1'b0; m_phase = 2; bus_idle();
                    end else begin
                        m_wait++;
                        if (m_wait == TIMEOUT) begin
                            exp_rd = '0; exp_done = 1'b1; exp_err = 1'b1; m_phase = 2; bus_idle();
                        end
                    end
                end
                default: begin
                    exp_done = 1'b0; exp_err = 1'b0; exp_ready = 1'b1; m_phase = 0;
                end
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (run_chk) begin
            chk("ready",   32'(ready_out),   32'(exp_ready));
            chk("done",    32'(done_out),    32'(exp_done));
            chk("err",     32'(err_out),     32'(exp_err));
            chk("rd_data", 32'(rd_data_out), 32'(exp_rd));
            chk("sel",     32'(sel_en_out),  32'(exp_sel));
            chk("wr_rd",   32'(wr_rd_s_out), 32'(exp_wr));
            chk("addr",    32'(addr_out),    32'(exp_addr));
            chk("wr_data", 32'(wr_data_out), 32'(exp_wd));
            chk("onehot",  32'($countones(sel_en_out) <= 1), 32'd1);
        end
    end

    // One-cycle request; returns at the falling edge just after acceptance.
    task automatic do_req(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        valid_in = 1'b1; wr_rd_s_in = wr; addr_in = a; wr_data_in = d;
        @(negedge clock);
        valid_in = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!ready_out && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("ready_wait", 32'(ready_out), 32'd1);
    endtask

    initial begin
        int hi;
        #1 reset = 1'b1;
        run_chk = 1'b1;
        @(negedge clock);
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_sel",   32'(sel_en_out), 32'd0);
        chk("rst_done",  32'(done_out),   32'd0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // Read, slave 2 acks on the first access cycle
        do_req(1'b0, 8'h45, 8'h00);
        chk("t1_sel", 32'(sel_en_out), 32'h04);
        ack_in = 5'b00100; rd_data_in = 8'h3C;
        @(negedge clock);
        ack_in = '0;
        chk("t1_done", 32'(done_out), 32'd1);
        chk("t1_err",  32'(err_out),  32'd0);
        chk("t1_rd",   32'(rd_data_out), 32'h3C);
        @(negedge clock);
        chk("t1_ready", 32'(ready_out), 32'd1);

        // Timeout with a spurious ack from an unselected slave
        rd_data_in = 8'h77;
        do_req(1'b0, 8'h10, 8'h00);
        hi = 0;
        while (sel_en_out != '0 && hi < 40) begin
            hi++;
            ack_in = (hi == 2) ? 5'b01000 : 5'b00000;
            @(negedge clock);
        end
        ack_in = '0;
        chk("t4_sel_cycles", 32'(hi), 32'd16);
        chk("t4_done", 32'(done_out), 32'd1);
        chk("t4_err",  32'(err_out),  32'd1);
        chk("t4_rd",   32'(rd_data_out), 32'h00);
        wait_ready();

        // Ack on the last permitted access cycle beats the timeout
        rd_data_in = 8'h5A;
        do_req(1'b0, 8'h30, 8'h00);
        repeat (15) @(negedge clock);
        chk("t5_sel_late", 32'(sel_en_out), 32'h02);
        ack_in = 5'b00010;
        @(negedge clock);
        ack_in = '0;
        chk("t5_done", 32'(done_out), 32'd1);
        chk("t5_err",  32'(err_out),  32'd0);
        chk("t5_rd",   32'(rd_data_out), 32'h5A);
        wait_ready();

        // Write to slave 4, ack after three waiting cycles
        do_req(1'b1, 8'h9F, 8'hA5);
        chk("t2_sel",  32'(sel_en_out),  32'h10);
        chk("t2_addr", 32'(addr_out),    32'h9F);
        chk("t2_wd",   32'(wr_data_out), 32'hA5);
        chk("t2_wr",   32'(wr_rd_s_out), 32'd1);
        repeat (3) @(negedge clock);
        chk("t2_sel_hold", 32'(sel_en_out), 32'h10);
        ack_in = 5'b10000;
        @(negedge clock);
        ack_in = '0;
        chk("t2_done", 32'(done_out), 32'd1);
        chk("t2_err",  32'(err_out),  32'd0);
        chk("t2_rd",   32'(rd_data_out), 32'h00);
        wait_ready();

        // Decode error: index 5 has no slave
        do_req(1'b0, 8'hA0, 8'h00);
        chk("t3_sel",  32'(sel_en_out), 32'd0);
        chk("t3_done", 32'(done_out), 32'd1);
        chk("t3_err",  32'(err_out),  32'd1);
        wait_ready();

        // Asynchronous reset in the middle of an access
        do_req(1'b0, 8'h65, 8'h00);
        @(negedge clock);
        chk("t6_sel_pre", 32'(sel_en_out), 32'h08);
        #1 reset = 1'b1;
        #1;
        chk("t6_sel",   32'(sel_en_out), 32'd0);
        chk("t6_ready", 32'(ready_out),  32'd1);
        chk("t6_done",  32'(done_out),   32'd0);
        #1 reset = 1'b0;
        @(negedge clock);
        rd_data_in = 8'hC3;
        do_req(1'b0, 8'h25, 8'h00);
        chk("t6b_sel", 32'(sel_en_out), 32'h02);
        ack_in = 5'b00010;
        @(negedge clock);
        ack_in = '0;
        chk("t6b_done", 32'(done_out), 32'd1);
        chk("t6b_err",  32'(err_out),  32'd0);
        chk("t6b_rd",   32'(rd_data_out), 32'hC3);
        wait_ready();
        @(negedge clock);

        run_chk = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
